// File: rtl/vec_pkg.sv
// Shared definitions for the vector sequencer: sizing defaults and FSM state type.
package vec_pkg;

  localparam int unsigned VLEN_MAX = 16;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vseq_state_e;

endpackage

// File: rtl/elem_counter.sv
// Element index register with load, advance and terminal-count detection.
module elem_counter #(
  parameter int unsigned VLEN_MAX = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [IDX_W:0]   vlen_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  localparam logic [IDX_W:0] VMAX = (IDX_W+1)'(VLEN_MAX);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  // One extra bit so a full-length vector reaches its terminal count without wrapping.
  logic [IDX_W:0] idx_q,  idx_d;
  logic [IDX_W:0] vlen_q, vlen_d;

  always_comb begin
    idx_d  = idx_q;
    vlen_d = vlen_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (load_i) begin
      idx_d  = '0;
      vlen_d = (vlen_i > VMAX) ? VMAX : vlen_i;
    end else if (adv_i) begin
      idx_d = idx_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      vlen_q <= '0;
    end else begin
      idx_q  <= idx_d;
      vlen_q <= vlen_d;
    end
  end

  assign idx_o  = idx_q[IDX_W-1:0];
  assign last_o = ((idx_q + ONE) == vlen_q);

endmodule

// File: rtl/vector_sequencer.sv
// Steps a vector instruction through its elements one lane-slot at a time,
// stalling the front end while running and pulsing done on completion.
module vector_sequencer #(
  parameter int unsigned VLEN_MAX = vec_pkg::VLEN_MAX,
  parameter int unsigned IDX_W    = vec_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_mem,
  input  logic [IDX_W:0]   vlen,
  input  logic             mem_ack,
  input  logic             flush,
  output logic             busy,
  output logic             vec_stall,
  output logic             elem_valid,
  output logic [IDX_W-1:0] elem_idx,
  output logic             mem_req,
  output logic             done
);

  import vec_pkg::*;

  vseq_state_e     state_q, state_d;
  logic            is_mem_q, is_mem_d;
  logic            cnt_clr, cnt_load, cnt_adv, cnt_last;
  logic [IDX_W-1:0] idx;

  elem_counter #(
    .VLEN_MAX (VLEN_MAX),
    .IDX_W    (IDX_W)
  ) u_elem_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .load_i (cnt_load),
    .adv_i  (cnt_adv),
    .vlen_i (vlen),
    .idx_o  (idx),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      is_mem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_mem_q <= is_mem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_mem_d   = is_mem_q;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_adv    = 1'b0;
    busy       = 1'b0;
    vec_stall  = 1'b0;
    elem_valid = 1'b0;
    elem_idx   = '0;
    mem_req    = 1'b0;
    done       = 1'b0;

    // Outputs depend on registered state only.
    case (state_q)
      RUN: begin
        busy       = 1'b1;
        vec_stall  = 1'b1;
        elem_valid = 1'b1;
        elem_idx   = idx;
        mem_req    = is_mem_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            if (vlen != '0) begin
              state_d  = RUN;
              cnt_load = 1'b1;
              is_mem_d = is_mem;
            end else begin
              state_d = DONE;
            end
          end
        end
        RUN: begin
          // An element completes every cycle for ALU ops, on mem_ack for memory ops.
          if (!is_mem_q || mem_ack) begin
            if (cnt_last) state_d = DONE;
            else          cnt_adv = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Randomized self-checking bench for vector_sequencer against a trace-level reference.
module tb_vector_sequencer;

  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             is_mem = 1'b0;
  logic [IDX_W:0]   vlen = '0;
  logic             mem_ack = 1'b0;
  logic             flush = 1'b0;
  logic             busy, vec_stall, elem_valid, mem_req, done;
  logic [IDX_W-1:0] elem_idx;

  int total = 0;
  int bad   = 0;

  vector_sequencer #(.VLEN_MAX(16), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_mem(is_mem), .vlen(vlen),
    .mem_ack(mem_ack), .flush(flush), .busy(busy), .vec_stall(vec_stall),
    .elem_valid(elem_valid), .elem_idx(elem_idx), .mem_req(mem_req), .done(done)
  );

  always #5 clk = ~clk;

  // {busy, vec_stall, elem_valid, mem_req, done, elem_idx}
  function automatic logic [8:0] obs();
    return {busy, vec_stall, elem_valid, mem_req, done, elem_idx};
  endfunction

  function automatic logic [8:0] run_word(int e, bit m);
    logic [3:0] i4;
    i4 = e[3:0];
    return {1'b1, 1'b1, 1'b1, m, 1'b0, i4};
  endfunction

  localparam logic [8:0] IDLE_W = 9'b0;
  localparam logic [8:0] DONE_W = 9'b0_0001_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (obs() !== IDLE_W) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", obs(), IDLE_W);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (obs() !== IDLE_W) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b", obs(), IDLE_W);
    end
  endtask

  // One cycle with no start; the sequencer must be quiet. Stray acks must be ignored.
  task automatic check_idle(string name);
    tick();
    start   = 1'b0;
    flush   = 1'b0;
    mem_ack = 1'($urandom % 2);
    total++;
    if (obs() !== IDLE_W) begin
      bad++;
      $display("FAIL %s_idle got=%b want=%b", name, obs(), IDLE_W);
    end
  endtask

  // Starts an instruction in the current cycle and checks every following cycle
  // through the done pulse. dly<0 picks a random ack delay per memory element.
  // Returns in the done cycle, so a following call is a back-to-back start.
  task automatic run_op(string name, int n, bit m, int dly);
    logic [8:0] exp_q[$];
    bit         ack_q[$];
    int         d;
    for (int e = 0; e < n; e++) begin
      d = !m ? 0 : (dly < 0 ? int'($urandom_range(0, 3)) : dly);
      for (int k = 0; k <= d; k++) begin
        exp_q.push_back(run_word(e, m));
        ack_q.push_back(m && (k == d));
      end
    end
    exp_q.push_back(DONE_W);
    ack_q.push_back(1'b0);

    start   = 1'b1;
    vlen    = 5'(n);
    is_mem  = m;
    flush   = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      if (i == exp_q.size() - 1) begin
        start   = 1'b0;
        mem_ack = 1'b0;
      end else begin
        start   = 1'($urandom % 2);
        vlen    = 5'($urandom_range(0, 16));
        is_mem  = 1'($urandom % 2);
        mem_ack = m ? ack_q[i] : 1'($urandom % 2);
      end
      total++;
      if (obs() !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cyc%0d got=%b want=%b", name, i + 1, obs(), exp_q[i]);
      end
    end
  endtask

  task automatic test_alu();
    run_op("alu4", 4, 1'b0, 0);
    check_idle("alu4");
    run_op("alu1", 1, 1'b0, 0);
    check_idle("alu1");
  endtask

  task automatic test_mem();
    run_op("mem2_d3", 2, 1'b1, 3);
    check_idle("mem2_d3");
    run_op("mem3_d0", 3, 1'b1, 0);
    check_idle("mem3_d0");
  endtask

  task automatic test_full_length();
    run_op("full16_alu", 16, 1'b0, 0);
    check_idle("full16_alu");
    run_op("full16_mem", 16, 1'b1, -1);
    check_idle("full16_mem");
  endtask

  task automatic test_zero_length();
    run_op("zero", 0, 1'b0, 0);
    check_idle("zero");
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 3, 1'b0, 0);
    run_op("b2b_b", 2, 1'b1, -1);
    run_op("b2b_c", 0, 1'b0, 0);
    run_op("b2b_d", 5, 1'b0, 0);
    check_idle("b2b");
  endtask

  task automatic test_flush();
    logic [8:0] want;
    start = 1'b1; vlen = 5'd5; is_mem = 1'b1; mem_ack = 1'b0; flush = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      start   = 1'b0;
      mem_ack = 1'b1;
      flush   = (e == 2);
      want    = run_word(e, 1'b1);
      total++;
      if (obs() !== want) begin
        bad++;
        $display("FAIL flush_pre%0d got=%b want=%b", e, obs(), want);
      end
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      flush   = 1'b0;
      mem_ack = 1'b0;
      total++;
      if (obs() !== IDLE_W) begin
        bad++;
        $display("FAIL flush_post%0d got=%b want=%b", c, obs(), IDLE_W);
      end
    end
    start = 1'b1; vlen = 5'd3; is_mem = 1'b0; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    total++;
    if (obs() !== IDLE_W) begin
      bad++;
      $display("FAIL flush_over_start got=%b want=%b", obs(), IDLE_W);
    end
    run_op("after_flush", 4, 1'b1, -1);
    check_idle("after_flush");
  endtask

  task automatic test_async_reset();
    start = 1'b1; vlen = 5'd8; is_mem = 1'b1; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (obs() !== run_word(0, 1'b1)) begin
      bad++;
      $display("FAIL rst_prerun got=%b want=%b", obs(), run_word(0, 1'b1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== IDLE_W) begin
      bad++;
      $display("FAIL rst_async got=%b want=%b", obs(), IDLE_W);
    end
    tick();
    total++;
    if (obs() !== IDLE_W) begin
      bad++;
      $display("FAIL rst_held got=%b want=%b", obs(), IDLE_W);
    end
    rst_n = 1'b1;
    check_idle("rst_release");
    run_op("rst_then3", 3, 1'b0, 0);
    check_idle("rst_then3");
  endtask

  task automatic test_random();
    int n;
    bit m;
    for (int r = 0; r < 24; r++) begin
      n = int'($urandom_range(0, 16));
      m = 1'($urandom % 2);
      run_op("rand", n, m, -1);
      if ($urandom % 2 == 0) check_idle("rand");
    end
    check_idle("rand_end");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_full_length();
    test_zero_length();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
